// File: rtl/tail_fifo_ctrl_21x6_pkg.sv
// tail_fifo_pkg
// Shared sizing, types and pointer arithmetic for the tail-tracking queue
// controller and its pointer sub-module.
//   DEPTH  : entries in the external tail_21x6 array
//   WIDTH  : entry width in bits
//   ADDR_W : pointer / peek offset width
//   CNT_W  : occupancy width (must hold 0..DEPTH)
package tail_fifo_pkg;

  localparam int DEPTH  = 21;
  localparam int WIDTH  = 6;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [WIDTH-1:0]  entry_t;

  // Which handshakes fire in a cycle; bit 0 = enqueue, bit 1 = dequeue.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  localparam ptr_t              LAST_PTR   = ptr_t'(DEPTH - 1);
  localparam cnt_t              FULL_CNT   = cnt_t'(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_WIDE = (ADDR_W + 1)'(DEPTH);

  // Advance a pointer by one, wrapping at the last entry rather than at 2^ADDR_W.
  function automatic ptr_t wrap_inc(ptr_t p);
    return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
  endfunction

  // Head plus offset modulo DEPTH; the sum is formed one bit wider so a
  // carry out of ADDR_W bits is not lost before the wrap test.
  function automatic ptr_t wrap_add(ptr_t h, ptr_t o);
    logic [ADDR_W:0] sum;
    sum = {1'b0, h} + {1'b0, o};
    if (sum >= DEPTH_WIDE) begin
      sum = sum - DEPTH_WIDE;
    end
    return sum[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/tail_fifo_ctrl_21x6_if.sv
// tail_fifo_ctrl_21x6_if
// Bundles the queue client handshakes and the array port signals of the
// tail queue controller.
//   master : queue client (drives enq/deq/peek requests and flush)
//   slave  : the controller itself
//   mem    : the tail_21x6 array (1 write port, 2 async read ports)
interface tail_fifo_ctrl_21x6_if;
  import tail_fifo_pkg::*;

  logic   flush;
  logic   enq_valid;
  logic   enq_ready;
  entry_t enq_bits;
  logic   deq_valid;
  logic   deq_ready;
  entry_t deq_bits;
  ptr_t   peek_offset;
  logic   peek_valid;
  entry_t peek_bits;
  cnt_t   count;

  ptr_t   mem_W0_addr;
  logic   mem_W0_en;
  entry_t mem_W0_data;
  ptr_t   mem_R0_addr;
  logic   mem_R0_en;
  entry_t mem_R0_data;
  ptr_t   mem_R1_addr;
  logic   mem_R1_en;
  entry_t mem_R1_data;

  modport master (
    output flush, enq_valid, enq_bits, deq_ready, peek_offset,
    input  enq_ready, deq_valid, deq_bits, peek_valid, peek_bits, count
  );

  modport slave (
    input  flush, enq_valid, enq_bits, deq_ready, peek_offset,
    output enq_ready, deq_valid, deq_bits, peek_valid, peek_bits, count,
    output mem_W0_addr, mem_W0_en, mem_W0_data,
    output mem_R0_addr, mem_R0_en, mem_R1_addr, mem_R1_en,
    input  mem_R0_data, mem_R1_data
  );

  modport mem (
    input  mem_W0_addr, mem_W0_en, mem_W0_data,
    input  mem_R0_addr, mem_R0_en, mem_R1_addr, mem_R1_en,
    output mem_R0_data, mem_R1_data
  );

endinterface

// File: rtl/tail_fifo_ctrl_21x6_ptr.sv
// tail_ptr_wrap
// Registered mod-DEPTH pointer with increment enable and synchronous clear.
//   clock : sole clock
//   reset : synchronous, active-high; forces pointer to 0
//   clear : synchronous clear (flush); wins over inc
//   inc   : advance the pointer by one with wrap at DEPTH-1
//   ptr   : current pointer value
module tail_ptr_wrap
  import tail_fifo_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output ptr_t ptr
);

  // Clear has priority over inc, so a flush never lets the pointer advance.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= wrap_inc(ptr);
    end
  end

  ptr_in_range: assert property (@(posedge clock) disable iff (reset) ptr <= LAST_PTR);

endmodule

// File: rtl/tail_fifo_ctrl_21x6.sv
// tail_fifo_ctrl_21x6
// Circular-queue controller owning head/tail pointers and occupancy for an
// external tail_21x6 array. Enqueue writes through W0, the head entry is read
// through R0, and R1 serves a random peek at head+offset.
//   clock : sole clock
//   reset : synchronous, active-high; empties the queue (array not cleared)
//   bus   : slave modport carrying flush, enq/deq/peek handshakes, count and
//           the W0/R0/R1 array ports
module tail_fifo_ctrl_21x6
  import tail_fifo_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  tail_fifo_ctrl_21x6_if.slave bus
);

  ptr_t  head;
  ptr_t  tail;
  cnt_t  count_q;
  cnt_t  count_d;
  logic  full;
  logic  empty;
  logic  enq_fire;
  logic  deq_fire;
  logic  peek_ok;
  q_op_e op;
  ptr_t  ring_dist;

  // Full blocks enqueue even when a dequeue fires in the same cycle.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign enq_fire = bus.enq_valid && !full;
  assign deq_fire = bus.deq_ready && !empty;
  assign op       = q_op_e'({deq_fire, enq_fire});
  assign peek_ok  = cnt_t'(bus.peek_offset) < count_q;

  tail_ptr_wrap u_head (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .inc   (deq_fire),
    .ptr   (head)
  );

  tail_ptr_wrap u_tail (
    .clock (clock),
    .reset (reset),
    .clear (bus.flush),
    .inc   (enq_fire),
    .ptr   (tail)
  );

  // Occupancy follows the fired handshakes; flush discards everything.
  always_comb begin
    count_d = count_q;
    case (op)
      OP_ENQ:  count_d = count_q + cnt_t'(1);
      OP_DEQ:  count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
    if (bus.flush) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The write goes out whenever enqueue fires, including a flush cycle; the
  // pointer does not move then, so the stale slot is simply overwritten later.
  assign bus.mem_W0_en   = enq_fire;
  assign bus.mem_W0_addr = tail;
  assign bus.mem_W0_data = bus.enq_bits;

  assign bus.mem_R0_addr = head;
  assign bus.mem_R0_en   = !empty;
  assign bus.mem_R1_addr = wrap_add(head, bus.peek_offset);
  assign bus.mem_R1_en   = peek_ok;

  assign bus.enq_ready  = !full;
  assign bus.deq_valid  = !empty;
  assign bus.deq_bits   = empty ? '0 : bus.mem_R0_data;
  assign bus.peek_valid = peek_ok;
  assign bus.peek_bits  = peek_ok ? bus.mem_R1_data : '0;
  assign bus.count      = count_q;

  // Forward distance tail-head around the ring; equals count except when full.
  always_comb begin
    ring_dist = tail - head;
    if (tail < head) begin
      ring_dist = tail - head + ptr_t'(DEPTH);
    end
  end

  deq_only_when_valid: assert property (@(posedge clock) disable iff (reset)
    !(deq_fire && !bus.deq_valid));

  count_in_range: assert property (@(posedge clock) disable iff (reset)
    count_q <= FULL_CNT);

  count_matches_ptrs: assert property (@(posedge clock) disable iff (reset)
    (count_q == FULL_CNT) ? (ring_dist == '0) : (count_q == cnt_t'(ring_dist)));

endmodule

// File: tb/tb_tail_fifo_ctrl_21x6.sv
// tb_tail_fifo_ctrl_21x6
// Pairs the controller with a behavioural tail_21x6 array and checks it
// against a queue-based reference: directed scenarios followed by random
// traffic with occasional flush and reset.
module tb_tail_fifo_ctrl_21x6;
  import tail_fifo_pkg::*;

  logic clock = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  // Reference contents, head first, and the scoreboard of expected dequeues.
  entry_t model_q[$];
  entry_t sb_q[$];
  // Entries written / removed since the last empty-making event; the
  // pointers are these totals modulo DEPTH.
  int     wr_total;
  int     rd_total;
  entry_t mem_array [DEPTH];

  tail_fifo_ctrl_21x6_if bus ();

  tail_fifo_ctrl_21x6 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Behavioural tail_21x6: one synchronous write port, two async read ports.
  always @(posedge clock) begin
    if (bus.mem_W0_en && (int'(bus.mem_W0_addr) < DEPTH)) begin
      mem_array[bus.mem_W0_addr] <= bus.mem_W0_data;
    end
  end

  always_comb begin
    bus.mem_R0_data = '0;
    bus.mem_R1_data = '0;
    if (int'(bus.mem_R0_addr) < DEPTH) bus.mem_R0_data = mem_array[bus.mem_R0_addr];
    if (int'(bus.mem_R1_addr) < DEPTH) bus.mem_R1_data = mem_array[bus.mem_R1_addr];
  end

  function automatic void checkEq(string name, int actual, int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endfunction

  // Scoreboard monitor: every dequeue handshake the DUT presents consumes
  // the oldest expected entry.
  always @(negedge clock) begin
    if (!reset && bus.deq_valid && bus.deq_ready) begin
      if (sb_q.size() == 0) begin
        checkEq("deq_unexpected_valid", int'(bus.deq_valid), 0);
      end else begin
        checkEq("deq_data", int'(bus.deq_bits), int'(sb_q.pop_front()));
      end
    end
  end

  // Compares the mid-cycle DUT outputs with the reference queue.
  task automatic checkOutput(input logic ev, input entry_t eb, input ptr_t po);
    int sz;
    int pk;
    sz = model_q.size();
    pk = int'(po);
    checkEq("count", int'(bus.count), sz);
    checkEq("enq_ready", int'(bus.enq_ready), (sz < DEPTH) ? 1 : 0);
    checkEq("deq_valid", int'(bus.deq_valid), (sz > 0) ? 1 : 0);
    checkEq("deq_bits", int'(bus.deq_bits), (sz > 0) ? int'(model_q[0]) : 0);
    if (sz > 0) checkEq("mem_R0_addr", int'(bus.mem_R0_addr), rd_total % DEPTH);
    checkEq("peek_valid", int'(bus.peek_valid), (pk < sz) ? 1 : 0);
    checkEq("peek_bits", int'(bus.peek_bits), (pk < sz) ? int'(model_q[pk]) : 0);
    if (pk < sz) checkEq("mem_R1_addr", int'(bus.mem_R1_addr), (rd_total + pk) % DEPTH);
    checkEq("mem_W0_en", int'(bus.mem_W0_en), (ev && (sz < DEPTH)) ? 1 : 0);
    if (ev && (sz < DEPTH)) begin
      checkEq("mem_W0_addr", int'(bus.mem_W0_addr), wr_total % DEPTH);
      checkEq("mem_W0_data", int'(bus.mem_W0_data), int'(eb));
    end
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic applyStimulus(input logic rst, input logic fl, input logic ev,
                               input entry_t eb, input logic dr, input ptr_t po);
    logic enq_ok;
    logic deq_ok;
    reset           = rst;
    bus.flush       = fl;
    bus.enq_valid   = ev;
    bus.enq_bits    = eb;
    bus.deq_ready   = dr;
    bus.peek_offset = po;
    @(negedge clock);
    checkOutput(ev, eb, po);
    enq_ok = ev && (model_q.size() < DEPTH);
    deq_ok = dr && (model_q.size() > 0);
    @(posedge clock);
    #1;
    if (rst || fl) begin
      model_q.delete();
      sb_q.delete();
      wr_total = 0;
      rd_total = 0;
    end else begin
      if (deq_ok) begin
        void'(model_q.pop_front());
        rd_total++;
      end
      if (enq_ok) begin
        model_q.push_back(eb);
        sb_q.push_back(eb);
        wr_total++;
      end
    end
  endtask

  task automatic enqN(input int n, input int base, input logic rnd);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, rnd ? entry_t'($urandom) : entry_t'(base + i), 1'b0, '0);
    end
  endtask

  task automatic deqN(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p_enq;
    for (int i = 0; i < DEPTH; i++) mem_array[i] = '0;
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.enq_valid   = 1'b0;
    bus.enq_bits    = '0;
    bus.deq_ready   = 1'b0;
    bus.peek_offset = '0;
    wr_total        = 0;
    rd_total        = 0;
    repeat (2) @(posedge clock);
    #1;

    // Reset state, then fill to full with 0x01..0x15; the extra enqueue is refused.
    enqN(21, 1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h3F, 1'b0, '0);

    // Drain in order back to empty.
    deqN(21);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Move both pointers to 20, then enqueue across the wrap.
    enqN(20, 0, 1'b1);
    deqN(20);
    enqN(5, 6'h2A, 1'b0);
    deqN(5);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Full with simultaneous enq/deq, then steady occupancy 10 with both firing.
    enqN(21, 0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 6'h15, 1'b1, '0);
    deqN(10);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, entry_t'($urandom), 1'b1, '0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Peek with head=18, count=6 across offsets 0..7.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    enqN(18, 0, 1'b1);
    deqN(18);
    enqN(6, 6'h30, 1'b0);
    for (int o = 0; o < 8; o++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, ptr_t'(o));
    end

    // Flush at count 7 with both handshakes requested.
    applyStimulus(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    enqN(7, 0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h11, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Reset in the middle of a burst drops the in-flight enqueue.
    enqN(5, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 6'h22, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Random traffic in phases that lean towards filling or draining.
    for (int ph = 0; ph < 12; ph++) begin
      p_enq = ph[0] ? 25 : 80;
      for (int c = 0; c < 50; c++) begin
        applyStimulus(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                      ($urandom_range(0, 99) < p_enq) ? 1'b1 : 1'b0,
                      entry_t'($urandom),
                      ($urandom_range(0, 99) < (105 - p_enq)) ? 1'b1 : 1'b0,
                      ptr_t'($urandom_range(0, 23)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
